vga_mem_reader: RTL
===================

VGA_MEM_READER -- requirements
Module: vga_mem_reader

Interface
REQ-001 Parameter DEPTH, default 8: prefetch FIFO depth in words (power of two).
REQ-002 Parameter READ_LATENCY, default 2: cycles from a granted read to valid mem_rdata.
REQ-003 Parameter FRAME_WORDS, default 153600: words per frame (640x480 pixels, two pixels per word).
REQ-004 Parameter BANK1_BASE, default 19'd262144: word address of frame bank 1; bank 0 base is 0.
REQ-005 clock  in  1  system clock; the block has one clock, and reset is synchronous and active-high.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 frame_flag  in  1  level; while high, the block flushes and rewinds to the selected bank base.
REQ-008 display_bank  in  1  bank to display; sampled every cycle frame_flag is high.
REQ-009 vga_flag  in  1  one-cycle request from the display stage for the next word.
REQ-010 vga_pixel  out  `LOG_MEM  word returned to the display stage (two packed pixels).
REQ-011 done_vga  out  1  one-cycle pulse marking vga_pixel as updated.
REQ-012 underflow  out  1  sticky flag: a request was served while the FIFO was empty.
REQ-013 mem_read  out  1  read request to the memory arbiter.
REQ-014 mem_addr  out  `LOG_ADDR  word address of the current read request.
REQ-015 mem_grant  in  1  arbiter accepts the request this cycle.
REQ-016 mem_rdata  in  `LOG_MEM  read data, valid exactly READ_LATENCY cycles after a grant.

Function
REQ-017 Issue rule: a read is issued in any cycle where mem_read and mem_grant are both high; mem_addr then increments by 1 at that edge.
REQ-018 mem_read is combinational and is high iff all of the following hold:
- reset is low and frame_flag is low;
- words issued this frame < FRAME_WORDS;
- FIFO count + reads in flight < DEPTH.
REQ-019 In-flight tracking: a READ_LATENCY-stage valid shift register advances every cycle and is loaded with 1 when a read is issued.
REQ-020 Push: mem_rdata is pushed into the FIFO only in a cycle where the last stage of the valid shift register is 1.
REQ-021 Overflow: the FIFO never overflows; REQ-018 guarantees this, and the bench shall assert it.
REQ-022 Pop and latency: vga_flag high with frame_flag low pops the FIFO head.
- The popped word is registered to vga_pixel at the next edge (cycle t+1).
- done_vga is high during cycle t+2 only.
- vga_pixel holds its value until the next pop.
REQ-023 Empty: a pop request with the FIFO empty loads vga_pixel with 0, still pulses done_vga at t+2, and sets underflow.
REQ-024 Simultaneous push and pop in one cycle leaves count unchanged; when the FIFO is empty, a same-cycle push is not bypassed to the pop.
REQ-025 Frame flush: every cycle frame_flag is high:
- FIFO count becomes 0;
- the valid shift register is cleared, so in-flight returns are discarded;
- the issued-word counter becomes 0;
- mem_addr is loaded with 0 (display_bank=0) or BANK1_BASE (display_bank=1).
REQ-026 vga_flag is ignored while frame_flag is high.
REQ-027 End of frame: after FRAME_WORDS reads have been issued, no further reads are issued until frame_flag rises; mem_addr holds at base+FRAME_WORDS.
REQ-028 Arithmetic: mem_addr and the word counter use natural width; the FIFO pointers wrap modulo DEPTH; count ranges 0..DEPTH.

Reset
REQ-029 Reset overrides every other input, including mid-read, mid-pop and frame_flag.
REQ-030 Reset values: vga_pixel=0, done_vga=0, underflow=0, mem_addr=0, FIFO count=0, valid shift register=0, word counter=0, pop pipeline=0.
REQ-031 mem_read is low while reset is high; returns arriving after reset deasserts from reads issued before reset are discarded.

Verification
REQ-032 Fill: reset, bank 0, mem_grant=1, no vga_flag -> reads to addresses 0..7, FIFO count reaches 8, mem_read then stays low.
REQ-033 Serve: FIFO holds words 0xA..0x11; vga_flag at cycle t -> vga_pixel=0xA from t+1, done_vga high at t+2 only; a refill read is issued once the slot frees.
REQ-034 Underflow: FIFO empty, vga_flag pulse -> vga_pixel=0, done_vga at t+2, underflow=1 and stays 1 until reset.
REQ-035 Flush mid-flight: two reads in flight, frame_flag high for 1 cycle with display_bank=1 -> both returns dropped, count=0, the next issued mem_addr is 262144.
REQ-036 Frame end: FRAME_WORDS overridden to 10, continuous grants and pops -> exactly 10 reads issued, mem_read then low; frame_flag pulse -> reads resume from the base.
REQ-037 Arbiter stall: mem_grant low for 5 cycles -> mem_addr and mem_read hold; no push, no increment.

Source files
------------

// File: rtl/vga_mem_reader.sv
// Prefetching frame-buffer reader for the VGA display stage.
// Keeps a small FIFO topped up from memory and serves one word per request.

`ifndef LOG_MEM
`define LOG_MEM 16
`endif
`ifndef LOG_ADDR
`define LOG_ADDR 19
`endif

module vga_mem_reader #(
    parameter int DEPTH        = 8,
    parameter int READ_LATENCY = 2,
    parameter int FRAME_WORDS  = 153600,
    parameter logic [`LOG_ADDR-1:0] BANK1_BASE = 19'd262144
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 frame_flag,
    input  logic                 display_bank,
    input  logic                 vga_flag,
    output logic [`LOG_MEM-1:0]  vga_pixel,
    output logic                 done_vga,
    output logic                 underflow,
    output logic                 mem_read,
    output logic [`LOG_ADDR-1:0] mem_addr,
    input  logic                 mem_grant,
    input  logic [`LOG_MEM-1:0]  mem_rdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(FRAME_WORDS + 1);
    localparam logic [WW-1:0] LAST = WW'(FRAME_WORDS);

    logic [`LOG_MEM-1:0]    fifo [DEPTH];
    logic [PW-1:0]          wptr;
    logic [PW-1:0]          rptr;
    logic [CW-1:0]          count;
    logic [READ_LATENCY-1:0] vsr;
    logic [READ_LATENCY:0]  vsr_next;
    logic [WW-1:0]          words;
    logic                   pop_d1;
    logic [31:0]            inflight;
    logic [31:0]            occ;
    logic                   issue;
    logic                   push;
    logic                   pop_req;
    logic                   pop;
    logic                   empty;

    // Reads in flight count against FIFO space so returns can never overflow it.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + 32'(vsr[i]);
        end
        occ = 32'(count) + inflight;
        mem_read = !reset && !frame_flag
                && (words < LAST)
                && (occ < 32'(DEPTH));
    end

    assign issue    = mem_read & mem_grant;
    assign push     = vsr[READ_LATENCY-1];
    assign pop_req  = vga_flag & ~frame_flag;
    assign empty    = (count == '0);
    assign pop      = pop_req & ~empty;
    assign vsr_next = {vsr, issue};

    always_ff @(posedge clock) begin
        if (!reset && !frame_flag && push) begin
            fifo[wptr] <= mem_rdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vga_pixel <= '0;
            done_vga  <= 1'b0;
            underflow <= 1'b0;
            mem_addr  <= '0;
            count     <= '0;
            wptr      <= '0;
            rptr      <= '0;
            vsr       <= '0;
            words     <= '0;
            pop_d1    <= 1'b0;
        end else begin
            pop_d1   <= pop_req;
            done_vga <= pop_d1;
            if (pop_req) begin
                vga_pixel <= empty ? '0 : fifo[rptr];
                if (empty) begin
                    underflow <= 1'b1;
                end
            end
            if (frame_flag) begin
                count    <= '0;
                wptr     <= '0;
                rptr     <= '0;
                vsr      <= '0;
                words    <= '0;
                mem_addr <= display_bank ? BANK1_BASE : '0;
            end else begin
                vsr <= vsr_next[READ_LATENCY-1:0];
                if (issue) begin
                    mem_addr <= mem_addr + `LOG_ADDR'(1);
                    words    <= words + WW'(1);
                end
                if (push) begin
                    wptr <= wptr + PW'(1);
                end
                if (pop) begin
                    rptr <= rptr + PW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

endmodule
